// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter for the async FIFO write port.
// Define FIFO_ARB_STALL_CNT_EN to build the full-stall counter.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic                     w_clk,
  input  logic                     w_rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic                     full,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     w_en,
  output logic [WIDTH-1:0]         data_in,
  output logic                     burst_active,
  output logic [$clog2(NUM_REQ)-1:0] owner_id,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [BC_W-1:0]   burst_cnt;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  hi_idx;
  logic [IDX_W-1:0]  lo_idx;
  logic              hi_found;
  logic              found;
  logic              burst_done;

  function automatic logic [IDX_W-1:0] nxt(
    input logic [IDX_W-1:0] p
  );
    return (p == IDX_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // lowest set req at or above rr_ptr, else lowest set req overall
  always_comb begin
    hi_found = 1'b0;
    found    = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found  = 1'b1;
        lo_idx = IDX_W'(i);
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

  assign burst_done = (burst_cnt == BC_W'(MAX_BURST));

  always_comb begin
    gnt = '0;
    if (!w_rst && !full) begin
      case (state)
        IDLE: begin
          if (found)
            gnt = NUM_REQ'(1) << winner;
        end
        BURST: begin
          if (req[owner_id] && !burst_done)
            gnt = NUM_REQ'(1) << owner_id;
        end
        default: gnt = '0;
      endcase
    end
  end

  always_comb begin
    data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i])
        data_in = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign w_en         = |gnt;
  assign burst_active = (state == BURST);

  // an exhausted burst hands the port back with a one-cycle bubble
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner_id  <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!full && found) begin
            owner_id <= winner;
            if (MAX_BURST == 1) begin
              rr_ptr <= nxt(winner);
            end else begin
              burst_cnt <= BC_W'(1);
              state     <= BURST;
            end
          end
        end
        BURST: begin
          if (!req[owner_id] || burst_done) begin
            state  <= IDLE;
            rr_ptr <= nxt(owner_id);
          end else if (!full) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst)
      stall_cnt <= '0;
    else if (full && |req && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (NUM_REQ=4, MAX_BURST=4).
// Inputs change on negedge; outputs sampled 1ns later.
module tb_fifo_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           w_clk = 1'b0;
  logic           w_rst = 1'b1;
  logic           full = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   gnt;
  logic           w_en;
  logic [W-1:0]   data_in;
  logic           burst_active;
  logic [1:0]     owner_id;
  logic [15:0]    stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 w_clk = ~w_clk;

  fifo_write_arbiter dut (
    .w_clk(w_clk),
    .w_rst(w_rst),
    .req(req),
    .req_data(req_data),
    .full(full),
    .gnt(gnt),
    .w_en(w_en),
    .data_in(data_in),
    .burst_active(burst_active),
    .owner_id(owner_id),
    .stall_cnt(stall_cnt)
  );

  task automatic do_reset;
    w_rst = 1'b1;
    req = '0;
    full = 1'b0;
    req_data = '0;
    repeat (2) @(negedge w_clk);
    w_rst = 1'b0;
  endtask

  task automatic test_reset;
    w_rst = 1'b1;
    req = 4'b1111;
    full = 1'b0;
    req_data = 32'hA5A5_A5A5;
    repeat (2) @(negedge w_clk);
    #1;
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL rst_gnt got=%b exp=0000", gnt);
    end
    checks++;
    if (w_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_w_en got=%b exp=0", w_en);
    end
    checks++;
    if (data_in !== 8'h00) begin
      failures++;
      $display("FAIL rst_data got=%h exp=00", data_in);
    end
    checks++;
    if (burst_active !== 1'b0) begin
      failures++;
      $display("FAIL rst_burst got=%b exp=0", burst_active);
    end
    checks++;
    if (owner_id !== 2'd0) begin
      failures++;
      $display("FAIL rst_owner got=%0d exp=0", owner_id);
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_stall got=%0d exp=0", stall_cnt);
    end
  endtask

  task automatic test_single;
    logic [7:0]   pat;
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    int sent;
    do_reset();
    pat = 8'b0110_1111;
    sent = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge w_clk);
      req = (sent < 6) ? 4'b0100 : 4'b0000;
      req_data[2*W +: W] = W'(8'h10 + sent);
      #1;
      eg = pat[c] ? 4'b0100 : 4'b0000;
      ed = pat[c] ? W'(8'h10 + sent) : '0;
      checks++;
      if (gnt !== eg) begin
        failures++;
        $display("FAIL single_gnt c=%0d got=%b exp=%b", c, gnt, eg);
      end
      checks++;
      if (data_in !== ed || w_en !== pat[c]) begin
        failures++;
        $display("FAIL single_data c=%0d got=%h/%b exp=%h/%b",
                 c, data_in, w_en, ed, pat[c]);
      end
      if (pat[c]) sent++;
    end
  endtask

  task automatic test_round_robin;
    int cnt [N];
    int own;
    logic         g;
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    do_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < 21; c++) begin
      @(negedge w_clk);
      req = 4'b1111;
      for (int i = 0; i < N; i++)
        req_data[i*W +: W] = W'(i * 16 + cnt[i]);
      #1;
      own = (c / 5) % 4;
      g = (c % 5) < 4;
      eg = g ? N'(1) << own : '0;
      ed = g ? W'(own * 16 + cnt[own]) : '0;
      checks++;
      if (gnt !== eg) begin
        failures++;
        $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, eg);
      end
      checks++;
      if (data_in !== ed) begin
        failures++;
        $display("FAIL rr_data c=%0d got=%h exp=%h", c, data_in, ed);
      end
      if (g) cnt[own]++;
    end
  endtask

  task automatic test_full_stall;
    logic [7:0]   gpat;
    logic [7:0]   fpat;
    logic [N-1:0] eg;
    int exp_stall;
    int sent;
`ifdef FIFO_ARB_STALL_CNT_EN
    exp_stall = 3;
`else
    exp_stall = 0;
`endif
    do_reset();
    gpat = 8'b0110_0011;
    fpat = 8'b0001_1100;
    sent = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge w_clk);
      req = 4'b0010;
      full = fpat[c];
      req_data[1*W +: W] = W'(8'h20 + sent);
      #1;
      eg = gpat[c] ? 4'b0010 : 4'b0000;
      checks++;
      if (gnt !== eg || w_en !== gpat[c]) begin
        failures++;
        $display("FAIL stall_gnt c=%0d got=%b/%b exp=%b/%b",
                 c, gnt, w_en, eg, gpat[c]);
      end
      if (fpat[c]) begin
        checks++;
        if (burst_active !== 1'b1) begin
          failures++;
          $display("FAIL stall_state c=%0d got=%b exp=1", c, burst_active);
        end
      end
      if (c == 5) begin
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
          failures++;
          $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall);
        end
        checks++;
        if (data_in !== 8'h22) begin
          failures++;
          $display("FAIL stall_data got=%h exp=22", data_in);
        end
      end
      if (gpat[c]) sent++;
    end
    full = 1'b0;
  endtask

  task automatic test_early_release;
    logic [N-1:0] rv [6];
    logic [N-1:0] ev [6];
    do_reset();
    rv = '{4'b0100, 4'b1001, 4'b1001, 4'b1001, 4'b0001, 4'b0001};
    ev = '{4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    req_data = 32'h4433_2211;
    for (int c = 0; c < 6; c++) begin
      @(negedge w_clk);
      req = rv[c];
      #1;
      checks++;
      if (gnt !== ev[c]) begin
        failures++;
        $display("FAIL early_gnt c=%0d got=%b exp=%b", c, gnt, ev[c]);
      end
      if (c == 4) begin
        checks++;
        if (owner_id !== 2'd3) begin
          failures++;
          $display("FAIL early_owner got=%0d exp=3", owner_id);
        end
      end
    end
    checks++;
    if (data_in !== 8'h11) begin
      failures++;
      $display("FAIL early_data got=%h exp=11", data_in);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    req_data = 32'h0033_2200;
    for (int c = 0; c < 3; c++) begin
      @(negedge w_clk);
      req = 4'b0100;
      #1;
      checks++;
      if (gnt !== 4'b0100) begin
        failures++;
        $display("FAIL mid_gnt c=%0d got=%b exp=0100", c, gnt);
      end
    end
    #2;
    w_rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000 || w_en !== 1'b0 || data_in !== 8'h00) begin
      failures++;
      $display("FAIL mid_rst got=%b/%b/%h exp=0000/0/00", gnt, w_en, data_in);
    end
    checks++;
    if (burst_active !== 1'b0 || owner_id !== 2'd0) begin
      failures++;
      $display("FAIL mid_state got=%b/%0d exp=0/0", burst_active, owner_id);
    end
    @(negedge w_clk);
    w_rst = 1'b0;
    req = 4'b0110;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL mid_after got=%b exp=0010", gnt);
    end
    checks++;
    if (data_in !== 8'h22) begin
      failures++;
      $display("FAIL mid_after_data got=%h exp=22", data_in);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
